// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage registers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pipe_pkg;

    // Occupancy of a stage register: no beat, head only, head plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // Default field widths of the existing per-stage banks.
    localparam int IF_ID_CTRL_W   = 1;
    localparam int IF_ID_DATA_W   = 64;   // instruction + PC+4
    localparam int ID_EX_CTRL_W   = 8;
    localparam int ID_EX_DATA_W   = 96;
    localparam int EX_MEM_CTRL_W  = 5;
    localparam int EX_MEM_DATA_W  = 69;
    localparam int SAD2_WB_CTRL_W = 3;    // RegWrite, MemtoReg, jal
    localparam int SAD2_WB_DATA_W = 69;

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+ctrl+data register slice with load and clear.
// Latency: loaded value visible one cycle after the load edge.
// Backpressure: none; the owner decides when to load or clear.
//
// Ports: Clk/Reset, load (capture ld_*), clear (drop valid, zero ctrl,
// keep data), ld_vld/ld_ctrl/ld_data source, vld/ctrl/data outputs.
import pipe_pkg::*;

module pipe_skid_entry #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              clear,
    input  logic              ld_vld,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              vld,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              vld_q,  vld_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clear wins over load. Data is deliberately kept on clear so the
    // payload bus does not toggle when a beat is killed.
    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clear) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
        end else if (load) begin
            vld_d  = ld_vld;
            ctrl_d = ld_vld ? ld_ctrl : '0;
            data_d = ld_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign ctrl = ctrl_q;
    assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready, stall, flush, optional skid.
// Latency: 1 cycle from accept to out_* when empty.
// Backpressure: SKID=1 registered in_ready (absorbs one beat after
//   out_ready drops); SKID=0 in_ready = out_ready | !out_valid.
//
// Ports: Clk, Reset (async active-low), in_valid/in_ready/in_ctrl/in_data
// upstream, flush, out_valid/out_ready/out_ctrl/out_data downstream,
// stall_cnt saturating count of cycles with out_valid & !out_ready.
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept, consume;
    logic              h_load, h_clear, h_from_skid;
    logic              s_load, s_clear;

    logic              h_vld,  s_vld;
    logic [CTRL_W-1:0] h_ctrl, s_ctrl;
    logic [DATA_W-1:0] h_data, s_data;

    logic              h_ld_vld;
    logic [CTRL_W-1:0] h_ld_ctrl;
    logic [DATA_W-1:0] h_ld_data;

    // A beat presented during flush is dropped even when in_ready is high.
    assign accept  = in_valid & in_ready & ~flush;
    assign consume = h_vld & out_ready;

    // ---------------- state register ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        h_load      = 1'b0;
        h_clear     = 1'b0;
        h_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            h_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        h_load  = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    // Without a skid entry an accept always coincides with
                    // a consume (or an empty head), so it replaces the head.
                    if (accept && (consume || SKID == 0)) begin
                        h_load = 1'b1;
                    end else if (accept) begin
                        s_load  = 1'b1;
                        state_d = TWO;
                    end else if (consume) begin
                        h_clear = 1'b1;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        h_load      = 1'b1;
                        h_from_skid = 1'b1;
                        s_clear     = 1'b1;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    h_clear = 1'b1;
                    s_clear = 1'b1;
                end
            endcase
        end
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        // Registered ready looks at the next occupancy, so no path from
        // out_ready reaches in_ready in the skid configuration.
        in_ready_d = (state_d != TWO);
        h_ld_vld   = h_from_skid ? s_vld  : 1'b1;
        h_ld_ctrl  = h_from_skid ? s_ctrl : in_ctrl;
        h_ld_data  = h_from_skid ? s_data : in_data;
        cnt_d      = cnt_q;
        if (h_vld && !out_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
        .Clk     (Clk),
        .Reset   (Reset),
        .load    (h_load),
        .clear   (h_clear),
        .ld_vld  (h_ld_vld),
        .ld_ctrl (h_ld_ctrl),
        .ld_data (h_ld_data),
        .vld     (h_vld),
        .ctrl    (h_ctrl),
        .data    (h_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .Clk     (Clk),
                .Reset   (Reset),
                .load    (s_load),
                .clear   (s_clear),
                .ld_vld  (1'b1),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .vld     (s_vld),
                .ctrl    (s_ctrl),
                .data    (s_data)
            );
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign s_vld    = 1'b0;
            assign s_ctrl   = '0;
            assign s_data   = '0;
            assign in_ready = out_ready | ~h_vld;
        end
    endgenerate

    assign out_valid = h_vld;
    assign out_ctrl  = h_vld ? h_ctrl : '0;
    assign out_data  = h_data;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        flush;
    logic        out_ready;
    logic        out_ready4;

    logic        in_ready,  out_valid;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;

    logic        in_ready0, out_valid0;
    logic [7:0]  out_ctrl0;
    logic [31:0] out_data0;
    logic [15:0] stall_cnt0;

    logic        in_ready4, out_valid4;
    logic [7:0]  out_ctrl4;
    logic [31:0] out_data4;
    logic [3:0]  stall_cnt4;

    int checks;
    int failures;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .stall_cnt(stall_cnt0)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_ctrl(out_ctrl4),
        .out_data(out_data4), .stall_cnt(stall_cnt4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[7:0] ^ 8'h80;
    endtask

    task automatic apply_reset();
        Reset      = 1'b0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
        #2;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        in_ctrl    = 8'hFF;
        flush      = 1'b0;
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_ctrl, out_data, stall_cnt} !== 57'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b c=%h d=%h s=%0d want all 0",
                     out_valid, out_ctrl, out_data, stall_cnt);
        end
        in_valid = 1'b0;
        Reset    = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            beat(32'(i));
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) ||
                out_ctrl !== (8'(i) ^ 8'h80) || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_beat%0d got v=%b d=%h c=%h rdy=%b want 1 %h %h 1",
                         i, out_valid, out_data, out_ctrl, in_ready, i, 8'(i) ^ 8'h80);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'd8) begin
            failures++;
            $display("FAIL stream_drain got v=%b c=%h d=%h want 0 00 8",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        beat(32'h1);
        tick();
        out_ready = 1'b0;
        beat(32'h2);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'h1) begin
            failures++;
            $display("FAIL stall_skid_full got rdy=%b d=%h want 0 1", in_ready, out_data);
        end
        beat(32'h3);
        repeat (4) tick();
        checks++;
        if (stall_cnt !== 16'd5 || in_ready !== 1'b0 || out_data !== 32'h1) begin
            failures++;
            $display("FAIL stall_hold got cnt=%0d rdy=%b d=%h want 5 0 1",
                     stall_cnt, in_ready, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h2 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got v=%b d=%h rdy=%b want 1 2 1",
                     out_valid, out_data, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h3) begin
            failures++;
            $display("FAIL stall_order3 got v=%b d=%h want 1 3", out_valid, out_data);
        end
        beat(32'h4);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 32'h4) begin
            failures++;
            $display("FAIL stall_order4 got d=%h want 4", out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd5) begin
            failures++;
            $display("FAIL stall_drain got v=%b cnt=%0d want 0 5", out_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        beat(32'h11);
        tick();
        beat(32'h22);
        tick();
        flush = 1'b1;
        beat(32'hAA);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h11 ||
            in_ready !== 1'b1 || stall_cnt !== 16'd2) begin
            failures++;
            $display("FAIL flush_two got v=%b c=%h d=%h rdy=%b cnt=%0d want 0 00 11 1 2",
                     out_valid, out_ctrl, out_data, in_ready, stall_cnt);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h11) begin
            failures++;
            $display("FAIL flush_no_aa got v=%b d=%h want 0 11", out_valid, out_data);
        end
        beat(32'h33);
        tick();
        flush = 1'b1;
        beat(32'hAA);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h33) begin
            failures++;
            $display("FAIL flush_one got v=%b c=%h d=%h want 0 00 33",
                     out_valid, out_ctrl, out_data);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h33) begin
            failures++;
            $display("FAIL flush_after got v=%b d=%h want 0 33", out_valid, out_data);
        end
    endtask

    task automatic test_noskid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            beat(32'h41 + 32'(i));
            tick();
            checks++;
            if (out_valid0 !== 1'b1 || out_data0 !== (32'h41 + 32'(i))) begin
                failures++;
                $display("FAIL noskid_stream%0d got v=%b d=%h want 1 %h",
                         i, out_valid0, out_data0, 32'h41 + 32'(i));
            end
        end
        out_ready = 1'b0;
        beat(32'h44);
        #1;
        checks++;
        if (in_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL noskid_rdy_low got %b want 0", in_ready0);
        end
        tick();
        checks++;
        if (out_data0 !== 32'h43 || stall_cnt0 !== 16'd1) begin
            failures++;
            $display("FAIL noskid_hold got d=%h cnt=%0d want 43 1", out_data0, stall_cnt0);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL noskid_rdy_high got %b want 1", in_ready0);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'h44) begin
            failures++;
            $display("FAIL noskid_replace got v=%b d=%h want 1 44", out_valid0, out_data0);
        end
        tick();
        checks++;
        if (out_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL noskid_drain got v=%b want 0", out_valid0);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        out_ready4 = 1'b0;
        beat(32'h1);
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        checks++;
        if (stall_cnt4 !== 4'd14) begin
            failures++;
            $display("FAIL sat_14 got %0d want 14", stall_cnt4);
        end
        repeat (6) tick();
        checks++;
        if (stall_cnt4 !== 4'd15 || out_valid4 !== 1'b1 || out_data4 !== 32'h1) begin
            failures++;
            $display("FAIL sat_15 got cnt=%0d v=%b d=%h want 15 1 1",
                     stall_cnt4, out_valid4, out_data4);
        end
        out_ready4 = 1'b1;
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        beat(32'h5);
        tick();
        beat(32'h6);
        tick();
        in_valid = 1'b0;
        #3;
        Reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_ctrl, out_data, stall_cnt} !== 57'd0) begin
            failures++;
            $display("FAIL async_reset got v=%b c=%h d=%h s=%0d want all 0",
                     out_valid, out_ctrl, out_data, stall_cnt);
        end
        #1;
        Reset     = 1'b1;
        out_ready = 1'b1;
        beat(32'h7);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h7 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL post_reset_beat got v=%b d=%h cnt=%0d want 1 7 0",
                     out_valid, out_data, stall_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_drain got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        in_valid = 1'b0;
        in_ctrl  = 8'h00;
        in_data  = 32'h0;
        flush    = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_noskid();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
